conv2d_weight_loader: RTL and testbench

- Writer side of the conv2d weight/bias memory.
- Accepts a byte-wide valid/ready stream from the host/DMA and packs each output channel's 27 signed 8-bit weights plus its 16-bit bias into one memory word.
- Issues one write per channel to the weight memory's write port, covering channels 0..NUM_OUT_CHANNELS-1 in order.
- Signals done or error to the control FSM.

---
 rtl/conv2d_weight_loader.sv | 170 +++++++++++++++++
 tb/tb_conv2d_weight_loader.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv2d_weight_loader.sv
// conv2d_weight_loader: writer side of the conv2d weight/bias memory.
// Packs each output channel's weights (byte stream, weight 0 first) and its
// little-endian bias into one memory word, then issues a single write per
// channel, channels in ascending order. Reports done or a sticky framing error.
module conv2d_weight_loader #(
  parameter int NUM_OUT_CHANNELS = 16,  // 2..256
  parameter int WEIGHT_WIDTH     = 8,   // one weight per stream byte
  parameter int WEIGHTS_PER_CH   = 27,
  parameter int BIAS_WIDTH       = 16,  // sent as BIAS_WIDTH/8 bytes, LSB first
  parameter int ADDR_WIDTH       = 8
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   start,
  input  logic                                   s_valid,
  output logic                                   s_ready,
  input  logic [7:0]                             s_data,
  input  logic                                   s_last,
  output logic                                   wr_en,
  output logic [ADDR_WIDTH-1:0]                  wr_addr,
  output logic [WEIGHTS_PER_CH*WEIGHT_WIDTH-1:0] wr_weights,
  output logic [BIAS_WIDTH-1:0]                  wr_bias,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   error
);

  localparam int BIAS_BYTES = BIAS_WIDTH / 8;
  localparam int IDX_W      = $clog2(WEIGHTS_PER_CH + 1);
  localparam int WB         = $clog2(WEIGHTS_PER_CH * WEIGHT_WIDTH);
  localparam int BB         = $clog2(BIAS_WIDTH);

  localparam logic [IDX_W-1:0]      LAST_W_IDX = IDX_W'(WEIGHTS_PER_CH - 1);
  localparam logic [IDX_W-1:0]      LAST_B_IDX = IDX_W'(BIAS_BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_CH    = ADDR_WIDTH'(NUM_OUT_CHANNELS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_LOAD_B,
    S_WRITE,
    S_DONE
  } state_e;

  state_e                                 state_q;
  logic [IDX_W-1:0]                       byte_idx_q;
  logic [ADDR_WIDTH-1:0]                  chan_q;
  logic                                   s_ready_q;
  logic                                   wr_en_q;
  logic [WEIGHTS_PER_CH*WEIGHT_WIDTH-1:0] wr_weights_q;
  logic [BIAS_WIDTH-1:0]                  wr_bias_q;
  logic                                   busy_q;
  logic                                   done_q;
  logic                                   error_q;

  logic             beat;
  logic             final_byte;
  logic             framing_abort;
  logic [WB-1:0]    w_lsb;
  logic [BB-1:0]    b_lsb;

  // Handshake uses the registered ready, so nothing here feeds back into s_ready.
  assign beat          = s_valid && s_ready_q;
  // The one byte allowed to carry s_last: bias high byte of the last channel.
  assign final_byte    = (state_q == S_LOAD_B) && (byte_idx_q == LAST_B_IDX) &&
                         (chan_q == LAST_CH);
  assign framing_abort = beat && s_last && !final_byte;
  assign w_lsb         = WB'(byte_idx_q) * WB'(WEIGHT_WIDTH);
  assign b_lsb         = BB'(byte_idx_q) * BB'(8);

  // Load FSM: collects bytes, issues one write per channel, reports completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      byte_idx_q   <= '0;
      chan_q       <= '0;
      s_ready_q    <= 1'b0;
      wr_en_q      <= 1'b0;
      // NOTE: the packing register is an output, so it is reset like any other
      // output; it is a flop bank, not a RAM, and resetting it costs nothing.
      wr_weights_q <= '0;
      wr_bias_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments only, so every branch below reads the
      // pre-edge value of each register regardless of statement order.
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;

      if (framing_abort) begin
        // Stray s_last: drop the byte, keep earlier writes, no done.
        error_q   <= 1'b1;
        busy_q    <= 1'b0;
        s_ready_q <= 1'b0;
        state_q   <= S_IDLE;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (start) begin
              state_q    <= S_LOAD_W;
              error_q    <= 1'b0;
              chan_q     <= '0;
              byte_idx_q <= '0;
              busy_q     <= 1'b1;
              s_ready_q  <= 1'b1;
            end
          end

          S_LOAD_W: begin
            if (beat) begin
              wr_weights_q[w_lsb +: 8] <= s_data;
              if (byte_idx_q == LAST_W_IDX) begin
                byte_idx_q <= '0;
                state_q    <= S_LOAD_B;
              end else begin
                byte_idx_q <= byte_idx_q + 1'b1;
              end
            end
          end

          S_LOAD_B: begin
            if (beat) begin
              wr_bias_q[b_lsb +: 8] <= s_data;
              if (byte_idx_q == LAST_B_IDX) begin
                // A final byte without s_last is flagged but still written.
                if (final_byte && !s_last) error_q <= 1'b1;
                s_ready_q <= 1'b0;
                wr_en_q   <= 1'b1;
                state_q   <= S_WRITE;
              end else begin
                byte_idx_q <= byte_idx_q + 1'b1;
              end
            end
          end

          S_WRITE: begin
            if (chan_q == LAST_CH) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              chan_q     <= chan_q + 1'b1;
              byte_idx_q <= '0;
              s_ready_q  <= 1'b1;
              state_q    <= S_LOAD_W;
            end
          end

          S_DONE: begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end

          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign s_ready    = s_ready_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = chan_q;
  assign wr_weights = wr_weights_q;
  assign wr_bias    = wr_bias_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_conv2d_weight_loader.sv
// Self-checking bench for conv2d_weight_loader with 4 output channels.
// The driver pushes each channel's expected write into a scoreboard queue once
// the channel's last byte is handed over; a negedge monitor pops and compares.
module tb_conv2d_weight_loader;

  localparam int N   = 4;
  localparam int WPC = 27;
  localparam int BPC = WPC + 2;

  typedef struct {
    logic [7:0]       addr;
    logic [WPC*8-1:0] w;
    logic [15:0]      b;
  } wr_t;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             s_valid;
  logic             s_ready;
  logic [7:0]       s_data;
  logic             s_last;
  logic             wr_en;
  logic [7:0]       wr_addr;
  logic [WPC*8-1:0] wr_weights;
  logic [15:0]      wr_bias;
  logic             busy;
  logic             done;
  logic             error;

  conv2d_weight_loader #(
    .NUM_OUT_CHANNELS(N),
    .WEIGHT_WIDTH    (8),
    .WEIGHTS_PER_CH  (WPC),
    .BIAS_WIDTH      (16),
    .ADDR_WIDTH      (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_weights(wr_weights),
    .wr_bias   (wr_bias),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  int  n_checks = 0;
  int  n_errors = 0;
  int  cyc      = 0;
  int  c0       = 0;
  int  wr_cnt   = 0;
  int  done_cnt = 0;
  int  done_cyc = 0;
  bit  done_err = 1'b0;
  int  stalls   = 0;
  wr_t exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard side: compare every write strobe against the oldest expectation.
  always @(negedge clk) begin
    if (wr_en) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        check("wr_unexpected", 1, 0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", wr_addr, e.addr);
        check("wr_weights", wr_weights, e.w);
        check("wr_bias", wr_bias, e.b);
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      done_err = error;
    end
    if (busy && s_ready && !s_valid) stalls++;
  end

  task automatic check_all_zero(input string pfx);
    check({pfx, "_s_ready"}, s_ready, 0);
    check({pfx, "_wr_en"}, wr_en, 0);
    check({pfx, "_wr_addr"}, wr_addr, 0);
    check({pfx, "_wr_weights"}, wr_weights, 0);
    check({pfx, "_wr_bias"}, wr_bias, 0);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_done"}, done, 0);
    check({pfx, "_error"}, error, 0);
  endtask

  task automatic start_load();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1;
    c0     = cyc;
    start  = 1'b0;
    wr_cnt = 0;
    stalls = 0;
    check("start_busy", busy, 1);
    check("start_err_clr", error, 0);
  endtask

  task automatic send_byte(input logic [7:0] d, input bit last);
    bit ok;
    ok      = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (s_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("hs_timeout", 0, 1);
    else begin
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Drives one full load. err_ch/err_byte place an early s_last; rst_ch/rst_byte
  // assert reset before that byte; poke pulses start during LOAD_W and WRITE.
  task automatic do_load(input bit gaps, input int err_ch, input int err_byte,
                         input bit omit_last, input int rst_ch, input int rst_byte,
                         input bit poke);
    start_load();
    for (int ch = 0; ch < N; ch++) begin
      wr_t e;
      e.addr = 8'(ch);
      e.b    = 16'(16'h1000 + ch);
      for (int k = 0; k < WPC; k++) e.w[k*8 +: 8] = 8'((ch * 27 + k) & 255);
      for (int b = 0; b < BPC; b++) begin
        logic [7:0] d;
        bit         last;
        if (ch == rst_ch && b == rst_byte) begin
          rst_n = 1'b0;
          return;
        end
        if (b < WPC)       d = e.w[b*8 +: 8];
        else if (b == WPC) d = e.b[7:0];
        else               d = e.b[15:8];
        last  = ((ch == N - 1) && (b == BPC - 1) && !omit_last) ||
                (ch == err_ch && b == err_byte);
        start = poke && ch == 1 && b == 5;
        send_byte(d, last);
        start = 1'b0;
        if (ch == err_ch && b == err_byte) return;
        if (b == BPC - 1) exp_q.push_back(e);
        if (poke && ch == 0 && b == BPC - 1) begin
          start = 1'b1;
          @(posedge clk);
          #1 start = 1'b0;
        end
        if (gaps && !(ch == N - 1 && b == BPC - 1)) begin
          @(posedge clk);
          #1;
        end
      end
    end
  endtask

  task automatic wait_done(input int target);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done_cnt >= target) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("done_timeout", 0, 1);
  endtask

  task automatic finish_checks(input string pfx, input int target, input bit exp_err);
    wait_done(target);
    check({pfx, "_done_cycle"}, done_cyc - c0 + 1, 30 * N + 1 + stalls);
    check({pfx, "_done_err"}, done_err, exp_err);
    check({pfx, "_writes"}, wr_cnt, N);
    check({pfx, "_sb_empty"}, exp_q.size(), 0);
    @(negedge clk);
    check({pfx, "_busy_low"}, busy, 0);
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Nominal gapless load.
    do_load(0, -1, -1, 0, -1, -1, 0);
    finish_checks("nominal", 1, 0);
    check("nominal_stalls", stalls, 0);

    // s_valid toggling every cycle.
    do_load(1, -1, -1, 0, -1, -1, 0);
    finish_checks("gaps", 2, 0);
    check("gaps_stalled", stalls > 0, 1);

    // Early s_last on byte 10 of channel 1.
    do_load(0, 1, 10, 0, -1, -1, 0);
    @(negedge clk);
    check("early_busy", busy, 0);
    check("early_err", error, 1);
    check("early_ready", s_ready, 0);
    repeat (5) @(negedge clk);
    check("early_err_sticky", error, 1);
    check("early_writes", wr_cnt, 1);
    check("early_no_done", done_cnt, 2);

    // Final byte without s_last: all writes, done with error.
    do_load(0, -1, -1, 1, -1, -1, 0);
    finish_checks("nolast", 3, 1);
    check("nolast_err_after", error, 1);

    // Reset after 15 bytes of channel 2, then a fresh load from address 0.
    do_load(0, -1, -1, 0, 2, 15, 0);
    #1;
    check_all_zero("midrst");
    check("midrst_writes", wr_cnt, 2);
    repeat (3) @(negedge clk);
    check("midrst_no_wr", wr_cnt, 2);
    rst_n = 1'b1;
    do_load(0, -1, -1, 0, -1, -1, 0);
    finish_checks("reload", 4, 0);

    // start pulsed during LOAD_W and WRITE is ignored.
    do_load(0, -1, -1, 0, -1, -1, 1);
    finish_checks("poke", 5, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
